// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock period monitor.
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    ACQ    = 2'd2,
    LOCKED = 2'd3
  } mon_state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Clear has priority over a coincident error pulse; the count sticks at max.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_next(
    input logic [ERR_CNT_W-1:0] cnt,
    input logic                 clr,
    input logic                 hit
  );
    if (clr) begin
      return '0;
    end
    if (hit && (cnt != ERR_CNT_MAX)) begin
      return cnt + ERR_CNT_W'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control and status bundle of the divided-clock monitor; the slave side is the monitor.
interface clk_div_monitor_if #(
  parameter int CNT_W = 16
) ();
  import clk_div_mon_pkg::*;

  logic                 enable;
  logic                 div_in;
  logic [CNT_W-1:0]     exp_period;
  logic                 err_clr;
  logic [CNT_W-1:0]     period;
  logic                 period_valid;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           state_o;

  modport master (
    output enable, div_in, exp_period, err_clr,
    input  period, period_valid, locked, err, err_count, state_o
  );

  modport slave (
    input  enable, div_in, exp_period, err_clr,
    output period, period_valid, locked, err, err_count, state_o
  );

endinterface

// File: rtl/clk_div_monitor_edge_sync.sv
// Samples the divided clock as data in the clk domain and flags its rising edges.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic rise
);

  logic s0_reg;
  logic s1_reg;
  logic prev_reg;

  // Two flops guard against metastability; the third gives the previous level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      s0_reg   <= div_in;
      s1_reg   <= s0_reg;
      prev_reg <= s1_reg;
    end
  end

  assign rise = s1_reg & ~prev_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in clk cycles, locks onto the expected period
// and reports mismatches and stalls once locked.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input logic              clk,
  input logic              reset,
  clk_div_monitor_if.slave bus
);

  localparam int               MC_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_COUNT - 1);

  logic                 rise;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W:0]       cnt_plus1;
  logic [CNT_W-1:0]     measured;
  logic [CNT_W:0]       exp_x;
  logic [CNT_W:0]       meas_x;
  logic [CNT_W:0]       diff;
  logic [CNT_W:0]       twice_exp;
  logic                 exp_ok;
  logic                 match;
  logic                 timeout;

  mon_state_t           state_reg;
  logic [MC_W-1:0]      match_cnt_reg;
  logic [CNT_W-1:0]     period_reg;
  logic                 period_valid_reg;
  logic                 locked_reg;
  logic                 err_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .div_in (bus.div_in),
    .rise   (rise)
  );

  // Cycles since the last rise; saturating so a dead input cannot wrap into a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (rise) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_plus1 = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
    measured  = cnt_plus1[CNT_W] ? CNT_MAX : cnt_plus1[CNT_W-1:0];
    exp_x     = {1'b0, bus.exp_period};
    meas_x    = {1'b0, measured};
    diff      = (meas_x >= exp_x) ? (meas_x - exp_x) : (exp_x - meas_x);
    twice_exp = {bus.exp_period, 1'b0};
    // Periods below 2 cannot be a real divider output, so comparison is switched off.
    exp_ok    = bus.exp_period > CNT_W'(1);
    match     = exp_ok && (diff <= TOL_X);
    timeout   = exp_ok && (cnt_plus1 >= twice_exp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      match_cnt_reg    <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      locked_reg       <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
      locked_reg       <= (state_reg == LOCKED);
      if (!bus.enable) begin
        state_reg     <= IDLE;
        match_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= SEEK;
          end
          SEEK: begin
            // First edge only starts a measurement window.
            if (rise) begin
              state_reg     <= ACQ;
              match_cnt_reg <= '0;
            end
          end
          ACQ: begin
            if (rise) begin
              period_reg       <= measured;
              period_valid_reg <= 1'b1;
              if (match) begin
                if (match_cnt_reg == LOCK_LAST) begin
                  state_reg     <= LOCKED;
                  match_cnt_reg <= '0;
                end else begin
                  match_cnt_reg <= match_cnt_reg + MC_W'(1);
                end
              end else begin
                match_cnt_reg <= '0;
              end
            end else if (timeout) begin
              state_reg <= SEEK;
            end
          end
          LOCKED: begin
            if (rise) begin
              period_reg       <= measured;
              period_valid_reg <= 1'b1;
              if (!match) begin
                err_reg       <= 1'b1;
                state_reg     <= ACQ;
                match_cnt_reg <= '0;
              end
            end else if (timeout) begin
              err_reg   <= 1'b1;
              state_reg <= SEEK;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Counts the registered err pulse, so a clear raised alongside a visible err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_reg <= '0;
    end else begin
      err_count_reg <= err_cnt_next(err_count_reg, bus.err_clr, err_reg);
    end
  end

  assign bus.period       = period_reg;
  assign bus.period_valid = period_valid_reg;
  assign bus.locked       = locked_reg;
  assign bus.err          = err_reg;
  assign bus.err_count    = err_count_reg;
  assign bus.state_o      = state_reg;

endmodule
